camera_downsampler: RTL and testbench
=====================================

Name: camera_downsampler

Overview:
- Front-end capture stage directly upstream of the colour/shape image processor.
- Takes the camera's 8-bit parallel RGB565 byte stream (two bytes per pixel) qualified by HREF/VSYNC, and packs each pixel to RGB332.
- Generates X/Y write addresses and a write strobe for the 176x144 frame buffer, which feeds the VGA path and the image processor.
- Flags frame boundaries and malformed lines.

Parameters:
- SCREEN_WIDTH, 176, pixels written per line; X range 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 144, lines written per frame; Y range 0..SCREEN_HEIGHT-1.
- ADDR_W, 8, width of X_ADDR and Y_ADDR.

Ports:
- CLK  in  1  camera pixel clock; every action is on posedge.
- RST_N  in  1  synchronous active-low reset.
- CAM_DATA  in  8  camera data byte.
- HREF  in  1  line-valid; bytes are sampled only while high.
- VSYNC  in  1  frame sync; rising edge marks end of frame.
- PIXEL_OUT  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- PIXEL_VALID  out  1  one-cycle write strobe for PIXEL_OUT at X_ADDR/Y_ADDR.
- X_ADDR  out  ADDR_W  column of PIXEL_OUT.
- Y_ADDR  out  ADDR_W  row of PIXEL_OUT.
- FRAME_DONE  out  1  one-cycle pulse on VSYNC rising edge.
- LINE_ERR  out  1  sticky per frame: some line's pixel count differed from SCREEN_WIDTH.

Behaviour:
- One clock; reset is synchronous and active-low (RST_N sampled on posedge CLK).
- Reset values:
  - PIXEL_OUT=0, PIXEL_VALID=0, X_ADDR=0, Y_ADDR=0, FRAME_DONE=0, LINE_ERR=0.
  - Byte phase=FIRST; internal x/y counters=0; last_href=0; last_vsync=0; held first byte=0.
- Reset mid-line discards any half pixel. Capture resumes on the next byte with HREF=1, starting at phase FIRST.
- Byte-phase FSM, states FIRST and SECOND:
  - FIRST & HREF=1: latch CAM_DATA as hi byte (R[4:0],G[5:3]); go to SECOND.
  - SECOND & HREF=1: form the pixel from hi byte and CAM_DATA (G[2:0],B[4:0]); go to FIRST.
  - HREF=0 in any state: go to FIRST. An odd trailing byte is dropped.
- Pixel packing, registered:
  - PIXEL_OUT <= {hi[7:5], hi[2:0], CAM_DATA[4:3]}.
  - PIXEL_OUT, X_ADDR and Y_ADDR update on the same edge that samples the second byte.
  - Latency: outputs valid the cycle after the second byte is presented.
- Write strobe:
  - PIXEL_VALID=1 for exactly that cycle, only if x<SCREEN_WIDTH and y<SCREEN_HEIGHT at the time of the write.
  - Otherwise PIXEL_VALID=0, the pixel is discarded and addresses are held.
- X counter:
  - Increments per completed pixel; saturates at SCREEN_WIDTH (no wrap).
  - Cleared on HREF falling edge (HREF=0 & last_href=1).
- Y counter:
  - On HREF falling edge, increments if x>0; saturates at SCREEN_HEIGHT.
  - Cleared on VSYNC rising edge.
- LINE_ERR:
  - On HREF falling edge, set if x!=SCREEN_WIDTH, or if the line exceeded SCREEN_WIDTH pixels.
  - Tracked with one overflow bit set when a pixel completes at x==SCREEN_WIDTH.
  - Cleared on VSYNC rising edge; the error of the frame just ended is visible in the FRAME_DONE cycle.
- FRAME_DONE=1 for one cycle after the VSYNC rising edge (VSYNC=1 & last_vsync=0).
- Bytes with HREF=1 while VSYNC=1 are ignored: no phase advance, no counter change.
- Simultaneous events:
  - VSYNC rise on the same edge as HREF fall: line end processed first, then y cleared; LINE_ERR reported, then cleared next frame.
  - HREF fall while a second byte is pending: pixel dropped, phase reset.
- Width arithmetic: counters are ADDR_W+1 bits so the saturation value is representable. X_ADDR/Y_ADDR are the low ADDR_W bits of the written coordinate.

Test Plan:
- Reset: RST_N=0 for 3 cycles mid-stream -> all outputs 0 on the cycle after the first low sample. After release, first byte pair 0xF8,0x1F yields PIXEL_OUT=0xE3 at X=0,Y=0 with PIXEL_VALID=1 for 1 cycle.
- Packing: byte pairs (0xF8,0x00),(0x07,0xE0),(0x00,0x1F),(0xFF,0xFF) -> PIXEL_OUT 0xE0,0x1C,0x03,0xFF at X=0..3, each one cycle after its second byte.
- Full frame: 144 lines x 352 bytes, then VSYNC pulse -> exactly 25344 PIXEL_VALID strobes, last at X=175,Y=143. FRAME_DONE single pulse; LINE_ERR=0.
- Short/odd line: one line of 351 bytes -> 175 pixels written, trailing byte dropped, next line starts at X=0. LINE_ERR=1 at FRAME_DONE, 0 after the next clean frame.
- Overlong frame: 180 pixels/line, 150 lines -> no strobe with X>175 or Y>143. Addresses hold at 175/143; LINE_ERR=1.
- Simultaneous: HREF falls on the same edge VSYNC rises -> Y cleared to 0, FRAME_DONE=1, next frame's first pixel at X=0,Y=0.

Source files
------------

// File: rtl/camera_downsampler.sv
// camera_downsampler: captures the camera's RGB565 byte stream, packs it to RGB332
// and produces frame-buffer write addresses, frame-done pulses and a per-frame line error.
module camera_downsampler #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        CAM_DATA,
    input  logic              HREF,
    input  logic              VSYNC,
    output logic [7:0]        PIXEL_OUT,
    output logic              PIXEL_VALID,
    output logic [ADDR_W-1:0] X_ADDR,
    output logic [ADDR_W-1:0] Y_ADDR,
    output logic              FRAME_DONE,
    output logic              LINE_ERR
);
    typedef enum logic {FIRST, SECOND} phase_t;

    localparam logic [ADDR_W:0] W = (ADDR_W+1)'(SCREEN_WIDTH);
    localparam logic [ADDR_W:0] H = (ADDR_W+1)'(SCREEN_HEIGHT);

    phase_t            phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   x_q, x_d, y_q, y_d;
    logic              ovf_q, ovf_d;
    logic              last_href_q, last_href_d, last_vsync_q, last_vsync_d;
    logic [7:0]        pix_q, pix_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] xa_q, xa_d, ya_q, ya_d;
    logic              done_q, done_d, err_q, err_d;
    logic              href_fall, vsync_rise;

    assign href_fall  = !HREF && last_href_q;
    assign vsync_rise = VSYNC && !last_vsync_q;

    always_comb begin
        phase_d      = phase_q;
        hi_d         = hi_q;
        x_d          = x_q;
        y_d          = y_q;
        ovf_d        = ovf_q;
        last_href_d  = HREF;
        last_vsync_d = VSYNC;
        pix_d        = pix_q;
        valid_d      = 1'b0;
        xa_d         = xa_q;
        ya_d         = ya_q;
        done_d       = vsync_rise;
        // the error of the ended frame stays visible during the FRAME_DONE cycle
        err_d        = done_q ? 1'b0 : err_q;
        if (!HREF) begin
            phase_d = FIRST;
        end else if (!VSYNC) begin
            if (phase_q == FIRST) begin
                hi_d    = CAM_DATA;
                phase_d = SECOND;
            end else begin
                phase_d = FIRST;
                if (x_q < W && y_q < H) begin
                    valid_d = 1'b1;
                    pix_d   = {hi_q[7:5], hi_q[2:0], CAM_DATA[4:3]};
                    xa_d    = x_q[ADDR_W-1:0];
                    ya_d    = y_q[ADDR_W-1:0];
                end
                if (x_q == W) ovf_d = 1'b1;
                else x_d = x_q + 1'b1;
            end
        end
        if (href_fall) begin
            x_d   = '0;
            ovf_d = 1'b0;
            if (x_q != '0 && y_q != H) y_d = y_q + 1'b1;
            if (x_q != W || ovf_q) err_d = 1'b1;
        end
        if (vsync_rise) y_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            phase_q      <= FIRST;
            hi_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            ovf_q        <= 1'b0;
            last_href_q  <= 1'b0;
            last_vsync_q <= 1'b0;
            pix_q        <= '0;
            valid_q      <= 1'b0;
            xa_q         <= '0;
            ya_q         <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ovf_q        <= ovf_d;
            last_href_q  <= last_href_d;
            last_vsync_q <= last_vsync_d;
            pix_q        <= pix_d;
            valid_q      <= valid_d;
            xa_q         <= xa_d;
            ya_q         <= ya_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign PIXEL_OUT   = pix_q;
    assign PIXEL_VALID = valid_q;
    assign X_ADDR      = xa_q;
    assign Y_ADDR      = ya_q;
    assign FRAME_DONE  = done_q;
    assign LINE_ERR    = err_q;
endmodule

// File: tb/tb_camera_downsampler.sv
// tb_camera_downsampler: directed and random line/frame sequences checked against
// a line-level model of which pixels land where in the 176x144 frame buffer.
module tb_camera_downsampler;
    localparam int W = 176;
    localparam int H = 144;

    logic       CLK = 1'b0, RST_N = 1'b0, HREF = 1'b0, VSYNC = 1'b0;
    logic [7:0] CAM_DATA = 8'h00;
    logic [7:0] PIXEL_OUT;
    logic       PIXEL_VALID;
    logic [7:0] X_ADDR, Y_ADDR;
    logic       FRAME_DONE, LINE_ERR;

    int total = 0, bad = 0, strobes = 0, fdones = 0;
    int line_y = 0, last_x = 0, last_y = 0;
    bit exp_err = 1'b0;
    logic [7:0] lb [$];

    camera_downsampler dut (
        .CLK(CLK), .RST_N(RST_N), .CAM_DATA(CAM_DATA), .HREF(HREF), .VSYNC(VSYNC),
        .PIXEL_OUT(PIXEL_OUT), .PIXEL_VALID(PIXEL_VALID), .X_ADDR(X_ADDR), .Y_ADDR(Y_ADDR),
        .FRAME_DONE(FRAME_DONE), .LINE_ERR(LINE_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
        int r, g, b;
        r = int'(hi) / 8;
        g = (int'(hi) % 8) * 8 + int'(lo) / 32;
        b = int'(lo) % 32;
        return 8'((r / 4) * 32 + (g / 8) * 4 + b / 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic href, input logic vs, input logic [7:0] d, input logic rst_n);
        HREF = href;
        VSYNC = vs;
        CAM_DATA = d;
        RST_N = rst_n;
        @(posedge CLK);
        #1;
        if (PIXEL_VALID) strobes++;
        if (FRAME_DONE) fdones++;
    endtask

    task automatic frame_checks();
        chk("frame_done", 32'(FRAME_DONE), 32'd1);
        chk("line_err_at_done", 32'(LINE_ERR), 32'(exp_err));
        tick(1'b0, 1'b1, 8'h00, 1'b1);
        chk("frame_done_width", 32'(FRAME_DONE), 32'd0);
        chk("line_err_cleared", 32'(LINE_ERR), 32'd0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        line_y = 0;
        exp_err = 1'b0;
    endtask

    task automatic end_frame();
        tick(1'b0, 1'b1, 8'h00, 1'b1);
        frame_checks();
    endtask

    // nb bytes on one HREF pulse; pixel k of the line is written only inside the frame
    task automatic send_line(input int nb, input bit rnd, input bit vs);
        int k;
        bit w;
        logic [7:0] hi, d;
        hi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            d = rnd ? 8'($urandom) : lb[i];
            tick(1'b1, 1'b0, d, 1'b1);
            if (i % 2 == 0) begin
                hi = d;
                chk("valid_on_first_byte", 32'(PIXEL_VALID), 32'd0);
            end else begin
                k = i / 2;
                w = k < W && line_y < H;
                chk("valid", 32'(PIXEL_VALID), 32'(w));
                if (w) begin
                    chk("pixel", 32'(PIXEL_OUT), 32'(rgb332(hi, d)));
                    last_x = k;
                    last_y = line_y;
                end
                chk("x_addr", 32'(X_ADDR), 32'(last_x));
                chk("y_addr", 32'(Y_ADDR), 32'(last_y));
            end
        end
        tick(1'b0, vs, 8'h00, 1'b1);
        chk("valid_after_line", 32'(PIXEL_VALID), 32'd0);
        if (nb / 2 != W) exp_err = 1'b1;
        if (nb / 2 > 0) line_y++;
        if (vs) frame_checks();
        else tick(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        int s0, f0;
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        chk("init_pix", 32'(PIXEL_OUT), 32'd0);
        chk("init_valid", 32'(PIXEL_VALID), 32'd0);
        chk("init_x", 32'(X_ADDR), 32'd0);
        chk("init_y", 32'(Y_ADDR), 32'd0);
        chk("init_done", 32'(FRAME_DONE), 32'd0);
        chk("init_err", 32'(LINE_ERR), 32'd0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);

        // reset lands mid-line with a half pixel pending
        tick(1'b1, 1'b0, 8'hFF, 1'b1);
        tick(1'b1, 1'b0, 8'hFF, 1'b1);
        chk("pre_reset_valid", 32'(PIXEL_VALID), 32'd1);
        chk("pre_reset_pix", 32'(PIXEL_OUT), 32'hFF);
        tick(1'b1, 1'b0, 8'hAA, 1'b1);
        tick(1'b1, 1'b0, 8'h55, 1'b0);
        chk("rst_pix", 32'(PIXEL_OUT), 32'd0);
        chk("rst_valid", 32'(PIXEL_VALID), 32'd0);
        chk("rst_x", 32'(X_ADDR), 32'd0);
        chk("rst_y", 32'(Y_ADDR), 32'd0);
        chk("rst_done", 32'(FRAME_DONE), 32'd0);
        chk("rst_err", 32'(LINE_ERR), 32'd0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        last_x = 0;
        last_y = 0;
        line_y = 0;
        exp_err = 1'b0;

        lb = '{8'hF8, 8'h1F};
        send_line(2, 1'b0, 1'b0);
        chk("first_pixel_const", 32'(PIXEL_OUT), 32'hE3);
        lb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
        send_line(8, 1'b0, 1'b0);
        chk("pack_last_const", 32'(PIXEL_OUT), 32'hFF);
        end_frame();

        s0 = strobes;
        f0 = fdones;
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b1, 1'b0);
        chk("full_last_x", 32'(X_ADDR), 32'd175);
        chk("full_last_y", 32'(Y_ADDR), 32'd143);
        end_frame();
        chk("full_strobes", 32'(strobes - s0), 32'(W * H));
        chk("full_done_pulses", 32'(fdones - f0), 32'd1);

        send_line(2 * W - 1, 1'b1, 1'b0);
        send_line(2 * W, 1'b1, 1'b0);
        end_frame();
        send_line(2 * W, 1'b1, 1'b0);
        send_line(2 * W, 1'b1, 1'b0);
        end_frame();

        // overlong lines around the top and bottom rows, short lines in between
        s0 = strobes;
        for (int l = 0; l < 3; l++) send_line(360, 1'b1, 1'b0);
        for (int l = 0; l < 140; l++) send_line(2, 1'b1, 1'b0);
        for (int l = 0; l < 7; l++) send_line(360, 1'b1, 1'b0);
        chk("over_hold_x", 32'(X_ADDR), 32'd175);
        chk("over_hold_y", 32'(Y_ADDR), 32'd143);
        chk("over_strobes", 32'(strobes - s0), 32'(3 * W + 140 + W));
        end_frame();

        send_line(2 * W, 1'b1, 1'b0);
        send_line(2 * W, 1'b1, 1'b1);
        send_line(4, 1'b1, 1'b0);
        chk("after_simul_y", 32'(Y_ADDR), 32'd0);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
